// File: rtl/linreg_pkg.sv
// rtl/linreg_pkg.sv - shared state encoding and default sizing for the regression blocks
package linreg_pkg;

    localparam int LR_NUM_SAMPLES   = 150;
    localparam int LR_COUNT_W       = 9;
    localparam int LR_SETTLE_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FETCH,
        ACCUM,
        SETTLE,
        DONE
    } seq_state_t;

endpackage

// File: rtl/linreg_settle_timer.sv
// rtl/linreg_settle_timer.sv - loadable 4-bit down-counter with zero flag
module linreg_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    // Parks at zero so the flag stays asserted until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/linreg_sequencer.sv
// rtl/linreg_sequencer.sv - control FSM fetching samples and strobing the regression accumulators
module linreg_sequencer
    import linreg_pkg::*;
#(
    parameter int NUM_SAMPLES   = LR_NUM_SAMPLES,
    parameter int COUNT_W       = LR_COUNT_W,
    parameter int SETTLE_CYCLES = LR_SETTLE_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    output logic               o_ldx,
    output logic               o_ldy,
    output logic               o_initsumx,
    output logic               o_initsumy,
    output logic               o_initsumxx,
    output logic               o_initsumxy,
    output logic               o_ldsumx,
    output logic               o_ldsumy,
    output logic               o_ldsumxx,
    output logic               o_ldsumxy,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_results_valid
);

    localparam logic [COUNT_W-1:0] LAST_IDX   = COUNT_W'(NUM_SAMPLES - 1);
    localparam logic [3:0]         SETTLE_TOP = 4'(SETTLE_CYCLES - 1);

    seq_state_t         r_state;
    seq_state_t         w_next;
    logic [COUNT_W-1:0] r_count;
    logic               r_results_valid;
    logic               w_last;
    logic               w_settle_load;
    logic               w_settle_zero;
    logic               w_init;
    logic               w_accum;

    assign w_last        = (r_count == LAST_IDX);
    assign w_settle_load = (r_state == ACCUM) && w_last;

    linreg_settle_timer u_settle (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_settle_load),
        .i_load_val (SETTLE_TOP),
        .o_zero     (w_settle_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        o_in_ready = 1'b0;
        w_init     = 1'b0;
        w_accum    = 1'b0;
        o_done     = 1'b0;
        o_busy     = 1'b1;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = INIT;
            end
            INIT: begin
                w_init = 1'b1;
                w_next = FETCH;
            end
            FETCH: begin
                o_in_ready = 1'b1;
                if (i_in_valid) w_next = ACCUM;
            end
            ACCUM: begin
                w_accum = 1'b1;
                w_next  = w_last ? SETTLE : FETCH;
            end
            SETTLE: begin
                if (w_settle_zero) w_next = DONE;
            end
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (i_abort) w_next = IDLE;
    end

    // Count is left alone by abort so it reports how many samples reached the sums.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count         <= '0;
            r_results_valid <= 1'b0;
        end else begin
            if (r_state == INIT) begin
                r_count <= '0;
            end else if (r_state == ACCUM) begin
                r_count <= r_count + 1'b1;
            end
            if (i_abort || (r_state == IDLE && i_start)) begin
                r_results_valid <= 1'b0;
            end else if (r_state == DONE) begin
                r_results_valid <= 1'b1;
            end
        end
    end

    assign o_ldx           = o_in_ready & i_in_valid;
    assign o_ldy           = o_in_ready & i_in_valid;
    assign o_initsumx      = w_init;
    assign o_initsumy      = w_init;
    assign o_initsumxx     = w_init;
    assign o_initsumxy     = w_init;
    assign o_ldsumx        = w_accum;
    assign o_ldsumy        = w_accum;
    assign o_ldsumxx       = w_accum;
    assign o_ldsumxy       = w_accum;
    assign o_count         = r_count;
    assign o_results_valid = r_results_valid;

endmodule
